// File: rtl/load_store_unit.sv
// load_store_unit
//
// Single-outstanding load/store unit that sits between the core and a simple
// request/grant memory bus. A start pulse in IDLE latches the address, store
// data, funct3 size code and direction. The request is then presented on the
// bus. Loads wait for read data, which is lane-selected and extended into rdata.
//
// Handshake: bus_req is held high with every bus_* output frozen, because they
// all derive from registers written only in IDLE. The transfer is accepted in
// the cycle where bus_req and bus_gnt are both high. For loads, the read data
// is accepted in the first cycle in WAIT with bus_rvalid high. bus_rvalid seen
// in any other state is dropped.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request pulse, only honoured in IDLE
//   addr, wdata       effective address and rs2-form store data
//   memop, we         funct3 size code (B/H/W/BU/HU) and store flag
//   busy, done        busy in every non-IDLE state, done for one cycle
//   rdata, fault      load result (held), fault qualified by done
//   bus_req/we/addr/wdata/wmask   word-aligned bus request
//   bus_gnt, bus_rvalid, bus_rdata   bus grant and read response
//   dbg_state         current FSM state for checkers
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses fault
//                         without touching the bus. When undefined, the low
//                         address bits are ignored for those sizes.

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  memop,
  input  logic        we,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  memop_q, memop_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic        illegal_op;
  logic        misaligned;
  logic        start_fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Request classification is done on the live inputs so that a faulting
  // request can go straight from IDLE to DONE.
  always_comb begin
    illegal_op = 1'b0;
    case (memop)
      OP_B, OP_H, OP_W: illegal_op = 1'b0;
      OP_BU, OP_HU:     illegal_op = we;  // unsigned stores do not exist
      default:          illegal_op = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if ((memop == OP_H || memop == OP_HU) && addr[0])
      misaligned = 1'b1;
    if (memop == OP_W && addr[1:0] != 2'b00)
      misaligned = 1'b1;
  end
`else
  // Misaligned halves and words are silently aligned by the lane logic below.
  assign misaligned = 1'b0;
`endif

  assign start_fault = illegal_op | misaligned;

  // Load lane selection and extension. Only legal load codes reach WAIT.
  always_comb begin
    ld_byte  = bus_rdata[8*addr_q[1:0] +: 8];
    ld_half  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_value = bus_rdata;
    case (memop_q)
      OP_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      OP_BU:   ld_value = {24'h0, ld_byte};
      OP_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      OP_HU:   ld_value = {16'h0, ld_half};
      default: ld_value = bus_rdata;
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    memop_d = memop_q;
    we_d    = we_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          memop_d = memop;
          we_d    = we;
          fault_d = start_fault;
          state_d = start_fault ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt)
          state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = ld_value;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      memop_q <= 3'b000;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs come only from registers, so they are stable through REQ and
  // collapse to zero while reset is asserted.
  always_comb begin
    bus_wmask = 4'b0000;
    bus_wdata = wdata_q;
    case (memop_q)
      OP_B: begin
        bus_wmask = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{wdata_q[7:0]}};
      end
      OP_H: begin
        bus_wmask = 4'b0011 << {addr_q[1], 1'b0};
        bus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        bus_wmask = 4'b1111;
        bus_wdata = wdata_q;
      end
    endcase
    if (!we_q)
      bus_wmask = 4'b0000;
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_DONE) & fault_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic        we;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rdata = 32'h0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .memop(memop), .we(we), .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, written directly from the size/extension rules
  function automatic bit model_fault(input logic [31:0] a, input logic [2:0] op, input bit w);
    bit f;
    f = (op == 3) || (op == 6) || (op == 7) || (w && (op == 4 || op == 5));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((op == 1 || op == 5) && (a % 2) != 0) f = 1;
    if (op == 2 && (a % 4) != 0) f = 1;
`endif
    return f;
  endfunction

  function automatic logic [3:0] model_mask(input logic [31:0] a, input logic [2:0] op, input bit w);
    if (!w) return 4'b0000;
    if (op == 0) return 4'(1 << (a % 4));
    if (op == 1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] op);
    if (op == 0) return (d & 32'hFF) * 32'h01010101;
    if (op == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] r);
    logic [31:0] v;
    if (op == 0 || op == 4) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (op == 0 && v >= 128) v = v - 256;
    end else if (op == 1 || op == 5) begin
      v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (op == 1 && v >= 32768) v = v - 65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Driver: one transaction with a responding bus. gnt_dly = extra REQ
  // cycles before grant, rv_dly = extra cycles between grant+1 and rvalid.
  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, input bit w, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rd, input bit noise);
    bit f;
    int exp_done, exp_req;
    int done_k = -1;
    int done_cnt = 0;
    int req_cnt = 0;
    int gnt_k = -1;
    bit fault_at_done = 0;
    bit fault_outside = 0;
    bit req_ok = 1;
    bit busy_ok = 1;
    logic [31:0] rdata_at_done = 32'h0;
    f = model_fault(a, op, w);
    exp_req  = f ? 0 : gnt_dly + 1;
    exp_done = f ? 1 : (w ? gnt_dly + 2 : gnt_dly + 3 + rv_dly);
    if (!f && !w) model_rdata = model_load(a, op, rd);
    addr = a; wdata = d; memop = op; we = w; start = 1'b1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= exp_done + 2; k++) begin
      if (bus_req) begin
        req_cnt++;
        if (bus_addr !== (a & ~32'h3) || bus_wmask !== model_mask(a, op, w) ||
            bus_we !== w || (w && bus_wdata !== model_wdata(d, op)))
          req_ok = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        fault_at_done = fault;
        rdata_at_done = rdata;
      end else if (fault !== 1'b0) begin
        fault_outside = 1;
      end
      if (busy !== (k <= exp_done)) busy_ok = 0;
      bus_gnt = bus_req && (req_cnt == gnt_dly + 1);
      if (bus_gnt) gnt_k = k;
      bus_rvalid = (gnt_k >= 0) && !w && (k == gnt_k + 1 + rv_dly);
      bus_rdata = bus_rvalid ? rd : $urandom;
      if (noise && bus_req && $urandom_range(0, 1) == 1) bus_rvalid = 1'b1;
      start = 1'b0;
      if (noise && busy && $urandom_range(0, 1) == 1) begin
        start = 1'b1; addr = $urandom; wdata = $urandom;
        memop = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check({name, "/done_cycle"}, 32'(done_k), 32'(exp_done));
    check({name, "/done_count"}, 32'(done_cnt), 32'd1);
    check({name, "/req_cycles"}, 32'(req_cnt), 32'(exp_req));
    check({name, "/bus_fields"}, 32'(req_ok), 32'd1);
    check({name, "/fault"}, 32'(fault_at_done), 32'(f));
    check({name, "/fault_outside_done"}, 32'(fault_outside), 32'd0);
    check({name, "/busy"}, 32'(busy_ok), 32'd1);
    check({name, "/rdata_at_done"}, rdata_at_done, model_rdata);
    check({name, "/rdata_after"}, rdata, model_rdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/done"}, 32'(done), 32'd0);
    check({tag, "/fault"}, 32'(fault), 32'd0);
    check({tag, "/bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "/bus_we"}, 32'(bus_we), 32'd0);
    check({tag, "/rdata"}, rdata, 32'h0);
    check({tag, "/bus_addr"}, bus_addr, 32'h0);
    check({tag, "/bus_wdata"}, bus_wdata, 32'h0);
    check({tag, "/bus_wmask"}, 32'(bus_wmask), 32'h0);
  endtask

  // Reset asserted mid-transaction (in REQ when to_wait=0, else in WAIT),
  // then a late rvalid which must be ignored.
  task automatic reset_mid_txn(input string name, input bit to_wait);
    int done_seen = 0;
    addr = 32'h40; wdata = 32'h0; memop = 3'b010; we = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "/req_before_reset"}, 32'(bus_req), 32'd1);
    if (to_wait) begin
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      check({name, "/in_wait"}, 32'({busy, bus_req}), 32'b10);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs({name, "/async"});
    model_rdata = 32'h0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    check({name, "/late_rvalid_ignored"}, 32'(done_seen), 32'd0);
    check({name, "/rdata_cleared"}, rdata, 32'h0);
  endtask

  initial begin
    logic [2:0] ops [8];
    logic [2:0] op;
    logic [31:0] a;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
    // Clock/reset
    rst_n = 1'b1; start = 1'b0; addr = '0; wdata = '0; memop = '0; we = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_txn("sw_0x100", 32'h100, 32'hDEADBEEF, 3'b010, 1, 0, 0, 32'h0, 0);
    run_txn("sb_0x203", 32'h203, 32'h000000A5, 3'b000, 1, 0, 0, 32'h0, 0);
    run_txn("lb_0x11", 32'h11, 32'h0, 3'b000, 0, 0, 0, 32'h00008000, 0);
    run_txn("lbu_0x11", 32'h11, 32'h0, 3'b100, 0, 0, 0, 32'h00008000, 0);
    run_txn("sh_0x102", 32'h102, 32'h1234BEEF, 3'b001, 1, 1, 0, 32'h0, 0);
    run_txn("lw_delayed", 32'h300, 32'h0, 3'b010, 0, 3, 1, 32'h89ABCDEF, 1);
    run_txn("lh_0x101", 32'h101, 32'h0, 3'b001, 0, 0, 0, 32'h8001F00F, 0);
    run_txn("lhu_0x102", 32'h102, 32'h0, 3'b101, 0, 0, 2, 32'hF00F1234, 0);
    run_txn("illegal_011", 32'h200, 32'h0, 3'b011, 0, 0, 0, 32'h0, 0);
    run_txn("illegal_sbu", 32'h200, 32'h55, 3'b100, 1, 0, 0, 32'h0, 0);
    run_txn("sw_misaligned", 32'h206, 32'h11223344, 3'b010, 1, 0, 0, 32'h0, 0);

    // Reset during REQ and during WAIT
    reset_mid_txn("reset_in_req", 0);
    reset_mid_txn("reset_in_wait", 1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(6, 7));
      a = $urandom;
      run_txn($sformatf("rand%0d", i), a, $urandom, op, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; reset is asynchronous and active-low.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start  in  1  one-cycle request pulse from the core; accepted only in IDLE.
REQ-004 SHALL have: addr  in  32  effective address, driven by the ALU sum output (aluresult).
REQ-005 SHALL have: wdata  in  32  store data, in rs2 form with the byte/half in the low bits.
REQ-006 SHALL have: memop  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have: we  in  1  1 = store, 0 = load.
REQ-008 SHALL have: busy  out  1, done  out  1, rdata  out  32, fault  out  1.
REQ-009 SHALL have: bus_req  out  1, bus_we  out  1, bus_addr  out  32, bus_wdata  out  32, bus_wmask  out  4.
REQ-010 SHALL have: bus_gnt  in  1, bus_rvalid  in  1, bus_rdata  in  32.

Function
REQ-011 SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-012 IDLE with start SHALL register addr, wdata, memop and we, then go to REQ (or to DONE on a fault); start outside IDLE SHALL be ignored.
REQ-013 REQ SHALL hold bus_req=1 and keep all bus_* outputs stable until bus_gnt is seen.
REQ-014 REQ with bus_gnt SHALL go to DONE for a store and to WAIT for a load.
REQ-015 WAIT SHALL go to DONE on bus_rvalid and SHALL ignore bus_rvalid in every other state.
REQ-016 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Latency with zero-wait bus: start at cycle N; store done at N+2; load done at N+3 when bus_rvalid arrives at N+2.
REQ-019 bus_addr SHALL be {addr[31:2],2'b00}.
REQ-020 bus_we SHALL equal the registered we.
REQ-021 bus_wmask for stores: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
REQ-022 bus_wmask for loads SHALL be 4'b0000.
REQ-023 bus_wdata: B = byte replicated x4; H = half replicated x2; W = wdata unchanged.
REQ-024 Load extraction SHALL select the byte lane addr[1:0] or the half lane addr[1] from bus_rdata.
REQ-025 Load extension: B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
REQ-026 rdata SHALL be captured on the WAIT-to-DONE transition and held until the next load completes.
REQ-027 Stores SHALL leave rdata unchanged.
REQ-028 An illegal memop (011, 110, 111, or BU/HU with we=1) SHALL set fault=1 with done, issue no bus request, and leave rdata unchanged.
REQ-029 fault SHALL be valid only while done=1 and SHALL be 0 otherwise.

Reset
REQ-030 rst_n low SHALL force IDLE immediately, at any state.
REQ-031 During reset, busy, done, fault, bus_req, bus_we SHALL be 0; rdata, bus_addr, bus_wdata SHALL be 32'h0; bus_wmask SHALL be 4'h0.
REQ-032 Reset during REQ or WAIT SHALL drop bus_req asynchronously and discard the transaction.
REQ-033 A late bus_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-034 The macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-035 With LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL go IDLE->DONE with fault=1, no bus access, and rdata unchanged.
REQ-036 Without the macro: misaligned addresses SHALL be silently aligned (H ignores addr[0]; W ignores addr[1:0]), and fault SHALL be raised only by REQ-028.

Verification
REQ-037 SW, addr=0x100, wdata=0xDEADBEEF, gnt in the first REQ cycle -> bus_addr=0x100, wmask=1111, done at N+2, fault=0.
REQ-038 SB, addr=0x203, wdata=0x000000A5 -> bus_addr=0x200, wmask=1000, bus_wdata=0xA5A5A5A5.
REQ-039 LB, addr=0x11, bus_rdata=0x0000_8000 -> rdata=0xFFFFFF80; LBU, same inputs -> rdata=0x00000080.
REQ-040 LW, gnt delayed 3 cycles, rvalid 2 cycles later -> bus_req held with stable addr for 4 cycles; single done; start pulses while busy are ignored.
REQ-041 LH, addr=0x101 -> with the macro: done at N+1, fault=1, bus_req never high; without the macro: bus access at 0x100, fault=0.
REQ-042 rst_n low during WAIT, then rvalid -> bus_req=0 immediately, no done, rdata=0.
